qrs_phase_controller: RTL and testbench
=======================================

// Module: qrs_phase_controller
// PURPOSE
//  Sequencer for the ECG QRS detection path. Runs the learn -> detect -> refractory cycle on the
//  wavelet-domain sample stream (d2n), using one sample_valid strobe per decimated sample.
//  In learn it derives the detection threshold from a running |max|. In detect it flags R peaks.
//  It measures R-R intervals and drives the enable/clear controls of the lifting, max and threshold stages.
// PARAMETERS
//  DW          32     sample/threshold width (signed samples, unsigned magnitude)
//  LEARN_LEN   512    samples accumulated in LEARN before threshold is published
//  REFRACT_LEN 50     samples ignored after a detected peak
//  TIMEOUT_LEN 1024   samples in DETECT without a peak before forced relearn
//  THR_SHIFT   2      threshold = max - (max >> THR_SHIFT)  (0.75*max at default)
//  RRW         16     R-R interval counter width
// PORTS
//  clk          in   1     system clock, all logic rising-edge
//  rst          in   1     asynchronous reset, active-high
//  start        in   1     one-cycle pulse; begins LEARN from IDLE, ignored otherwise
//  stop         in   1     one-cycle pulse; returns to IDLE from any state
//  sample_valid in   1     qualifies sample, at most one per cycle
//  sample       in   DW    signed wavelet coefficient
//  lift_en      out  1     enables preprocessing lifting stage (high in all states but IDLE)
//  max_clr      out  1     one-cycle clear to max stage on every entry to LEARN
//  threshold    out  DW    current detection threshold (unsigned)
//  thr_valid    out  1     high once a threshold has been published, until IDLE
//  peak_pulse   out  1     one-cycle pulse per detected R peak
//  peak_value   out  DW    |sample| of last detected peak
//  rr_interval  out  RRW   samples between last two peaks
//  rr_valid     out  1     one-cycle pulse with each new rr_interval
//  state_o      out  2     IDLE=0 LEARN=1 DETECT=2 REFRACT=3
// BEHAVIOUR
//  Reset: state IDLE; every output 0; every counter and max register 0.
//  |sample|: two's-complement magnitude. The most negative value saturates to 2^(DW-1)-1.
//  IDLE -> LEARN on start. Entry pulses max_clr and clears max_reg and scnt.
//  LEARN: on each sample_valid, max_reg <= max(max_reg, |sample|) and scnt++. On the LEARN_LEN-th sample:
//    threshold <= m - (m >> THR_SHIFT), where m is max_reg including that sample.
//    thr_valid <= 1; -> DETECT next cycle. If m == 0, threshold = 1 (never 0).
//  DETECT: each sample_valid increments rr_cnt (saturating at 2^RRW-1) and to_cnt.
//    When |sample| > threshold (strict), the next cycle gives peak_pulse=1, peak_value=|sample|.
//    -> REFRACT with rcnt=0, to_cnt=0.
//    On that peak, if a previous peak exists: rr_interval <= rr_cnt + 1 and rr_valid pulses.
//    rr_cnt <= 0. The first peak after LEARN only arms RR (no rr_valid).
//    When to_cnt reaches TIMEOUT_LEN with no peak -> LEARN (max_clr, RR disarmed).
//  REFRACT: samples are not compared but still increment rr_cnt. After REFRACT_LEN samples -> DETECT.
//  stop has priority over all transitions. It forces IDLE, clears thr_valid and lift_en, and keeps threshold.
//  start in same cycle as stop: stop wins. start outside IDLE: ignored.
//  Peak compare and timeout on the same sample: the peak wins.
//  Peak and LEARN-completion decisions use that cycle's sample; a sample arriving on a transition cycle
//  belongs to the old state.
//  rst mid-operation: immediate return to reset values, with no pulses emitted.
// CONFIGURATION
//  ADAPTIVE_THR_EN defined: on each accepted peak, threshold <= thr - (thr>>3) + (t>>3),
//    where t = peak - (peak >> THR_SHIFT). Arithmetic is in DW+1 bits then clamped to >= 1.
//    Updated value is visible the cycle after peak_pulse.
//  Not defined: threshold changes only at end of LEARN (including relearn after timeout).
// STRUCTURE
//  Package ecg_ctrl_pkg: state encoding localparams (IDLE/LEARN/DETECT/REFRACT), DW/RRW defaults,
//    abs-saturate function.
//  Sub-module ecg_abs_max: registered |x| running-max with clear and valid. This is the only child.
//    FSM, counters and threshold math stay in this module.
// TESTING
//  T1 reset mid-DETECT: assert rst -> all outputs 0, state_o=0, no peak_pulse on release.
//  T2 LEARN_LEN=8, samples 10,-40,25,...,max |.|=40 -> threshold=30, thr_valid=1, state_o=2 one cycle after 8th.
//  T3 threshold 30, sample 30 -> no peak; sample -31 -> peak_pulse, peak_value=31, state_o=3 for REFRACT_LEN samples.
//  T4 peaks 100 samples apart (REFRACT_LEN=50) -> second peak gives rr_valid with rr_interval=100; first gives none.
//  T5 no sample above threshold for TIMEOUT_LEN samples -> state_o=1, max_clr pulse, rr disarmed.
//  T6 sample = -2^31 in LEARN -> magnitude 2^31-1; stop+start same cycle -> IDLE, thr_valid=0.

Source files
------------

// File: rtl/ecg_ctrl_pkg.sv
// Shared definitions for the QRS detection sequencer: state encoding, default widths, |x| helper.
// Latency: n/a (types, constants and a combinational function only).
// Backpressure: n/a.
package ecg_ctrl_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_LEARN   = 2'd1;
   localparam logic [1:0] ST_DETECT  = 2'd2;
   localparam logic [1:0] ST_REFRACT = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      LEARN   = ST_LEARN,
      DETECT  = ST_DETECT,
      REFRACT = ST_REFRACT
   } state_t;

   localparam int DW_DEF  = 32;
   localparam int RRW_DEF = 16;

   // Two's-complement magnitude of a w-bit value carried sign-extended in 64 bits.
   // The most negative w-bit value has no positive twin, so it saturates to 2^(w-1)-1.
   function automatic logic [63:0] abs_sat(input logic signed [63:0] x, input int w);
      logic signed [63:0] lo;
      lo = -(64'sd1 <<< (w - 1));
      if (x == lo)
         return (64'd1 << (w - 1)) - 64'd1;
      else if (x < 64'sd0)
         return $unsigned(-x);
      else
         return $unsigned(x);
   endfunction

endpackage

// File: rtl/ecg_abs_max.sv
// Saturating |x| of the incoming sample and a running maximum of the accepted magnitudes.
// Latency: mag and max_nxt are combinational; the held maximum updates on the next clock.
// Backpressure: none; en qualifies each sample, clr empties the maximum and wins over en.
module ecg_abs_max
   import ecg_ctrl_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 en,
   input  logic signed [DW-1:0] x,
   output logic [DW-1:0]        mag,
   output logic [DW-1:0]        max_nxt
);

   logic [DW-1:0] max_q;

   // Magnitude of the current sample, and the maximum as it would be with that sample folded in.
   always_comb begin
      mag     = DW'(abs_sat(64'(x), DW));
      max_nxt = (en && (mag > max_q)) ? mag : max_q;
   end

   // Hold the running maximum; a clear empties it regardless of the current sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         max_q <= '0;
      else if (clr)
         max_q <= '0;
      else
         max_q <= max_nxt;
   end

endmodule

// File: rtl/qrs_phase_controller.sv
// QRS sequencer: learn a threshold from the running |max|, detect R peaks, hold off, measure R-R.
// Latency: state, threshold, peak and R-R outputs update on the clock edge of the deciding sample.
// Backpressure: none; one sample per sample_valid is always consumed. ADAPTIVE_THR_EN enables peak-tracking threshold.
module qrs_phase_controller
   import ecg_ctrl_pkg::*;
#(
   parameter int DW          = DW_DEF,
   parameter int LEARN_LEN   = 512,
   parameter int REFRACT_LEN = 50,
   parameter int TIMEOUT_LEN = 1024,
   parameter int THR_SHIFT   = 2,
   parameter int RRW         = RRW_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 sample_valid,
   input  logic signed [DW-1:0] sample,
   output logic                 lift_en,
   output logic                 max_clr,
   output logic [DW-1:0]        threshold,
   output logic                 thr_valid,
   output logic                 peak_pulse,
   output logic [DW-1:0]        peak_value,
   output logic [RRW-1:0]       rr_interval,
   output logic                 rr_valid,
   output logic [1:0]           state_o
);

   localparam int SCW = $clog2(LEARN_LEN + 1);
   localparam int RCW = $clog2(REFRACT_LEN + 1);
   localparam int TOW = $clog2(TIMEOUT_LEN + 1);

   state_t state, state_n;

   logic [SCW-1:0] scnt;
   logic [RCW-1:0] rcnt;
   logic [TOW-1:0] to_cnt;
   logic [RRW-1:0] rr_cnt;
   logic [RRW-1:0] rr_inc;
   logic           rr_armed;

   logic [DW-1:0]  mag;
   logic [DW-1:0]  max_nxt;

   logic learn_en;
   logic learn_done;
   logic is_peak;
   logic timeout;
   logic refr_done;
   logic enter_learn;

   // Published threshold is a fixed fraction of the learned maximum, but never zero so
   // that an all-zero learn window cannot turn every nonzero sample into a peak.
   function automatic logic [DW-1:0] learn_thr(input logic [DW-1:0] m);
      if (m == '0)
         return DW'(1);
      return m - (m >> THR_SHIFT);
   endfunction

   // Only samples that arrive while still in LEARN (and not being stopped) feed the maximum.
   assign learn_en   = (state == LEARN) && sample_valid && !stop;
   assign learn_done = (state == LEARN) && sample_valid && (scnt == SCW'(LEARN_LEN - 1));
   assign is_peak    = (state == DETECT) && sample_valid && (mag > threshold);
   assign timeout    = (state == DETECT) && sample_valid && (to_cnt == TOW'(TIMEOUT_LEN - 1));
   assign refr_done  = (state == REFRACT) && sample_valid && (rcnt == RCW'(REFRACT_LEN - 1));
   assign rr_inc     = (rr_cnt == '1) ? rr_cnt : rr_cnt + RRW'(1);
   assign state_o    = state;

   ecg_abs_max #(
      .DW (DW)
   ) u_abs_max (
      .clk     (clk),
      .rst     (rst),
      .clr     (enter_learn),
      .en      (learn_en),
      .x       (sample),
      .mag     (mag),
      .max_nxt (max_nxt)
   );

`ifdef ADAPTIVE_THR_EN
   logic [DW:0]   pk_ext;
   logic [DW:0]   thr_ext;
   logic [DW:0]   t_ext;
   logic [DW:0]   adapt_sum;
   logic [DW-1:0] adapt_thr;

   // Blend 1/8 of the latest peak's target level into the threshold, one bit of headroom, floor of 1.
   always_comb begin
      pk_ext    = {1'b0, peak_value};
      thr_ext   = {1'b0, threshold};
      t_ext     = pk_ext - (pk_ext >> THR_SHIFT);
      adapt_sum = thr_ext - (thr_ext >> 3) + (t_ext >> 3);
      if (adapt_sum == '0)
         adapt_thr = DW'(1);
      else if (adapt_sum[DW])
         adapt_thr = '1;
      else
         adapt_thr = adapt_sum[DW-1:0];
   end
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   // Next state; stop overrides everything, a peak beats a timeout on the same sample.
   always_comb begin
      state_n     = state;
      enter_learn = 1'b0;
      lift_en     = (state != IDLE);
      if (stop) begin
         state_n = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_n     = LEARN;
                  enter_learn = 1'b1;
               end
            end
            LEARN: begin
               if (learn_done)
                  state_n = DETECT;
            end
            DETECT: begin
               if (is_peak) begin
                  state_n = REFRACT;
               end else if (timeout) begin
                  state_n     = LEARN;
                  enter_learn = 1'b1;
               end
            end
            REFRACT: begin
               if (refr_done)
                  state_n = DETECT;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Counters, threshold publication, peak reporting and R-R measurement.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         max_clr     <= 1'b0;
         threshold   <= '0;
         thr_valid   <= 1'b0;
         peak_pulse  <= 1'b0;
         peak_value  <= '0;
         rr_interval <= '0;
         rr_valid    <= 1'b0;
         scnt        <= '0;
         rcnt        <= '0;
         to_cnt      <= '0;
         rr_cnt      <= '0;
         rr_armed    <= 1'b0;
      end else begin
         peak_pulse <= 1'b0;
         rr_valid   <= 1'b0;
         max_clr    <= enter_learn;
         if (stop) begin
            thr_valid <= 1'b0;
            rr_armed  <= 1'b0;
            scnt      <= '0;
            rcnt      <= '0;
            to_cnt    <= '0;
            rr_cnt    <= '0;
         end else begin
`ifdef ADAPTIVE_THR_EN
            if (peak_pulse)
               threshold <= adapt_thr;
`endif
            case (state)
               LEARN: begin
                  if (sample_valid) begin
                     if (learn_done) begin
                        threshold <= learn_thr(max_nxt);
                        thr_valid <= 1'b1;
                        scnt      <= '0;
                     end else begin
                        scnt <= scnt + SCW'(1);
                     end
                  end
               end
               DETECT: begin
                  if (sample_valid) begin
                     if (is_peak) begin
                        peak_pulse <= 1'b1;
                        peak_value <= mag;
                        if (rr_armed) begin
                           rr_interval <= rr_inc;
                           rr_valid    <= 1'b1;
                        end
                        rr_armed <= 1'b1;
                        rr_cnt   <= '0;
                        rcnt     <= '0;
                        to_cnt   <= '0;
                     end else begin
                        rr_cnt <= rr_inc;
                        to_cnt <= to_cnt + TOW'(1);
                     end
                  end
               end
               REFRACT: begin
                  if (sample_valid) begin
                     rr_cnt <= rr_inc;
                     rcnt   <= refr_done ? '0 : rcnt + RCW'(1);
                  end
               end
               default: ;
            endcase
            // A fresh learn window starts with no R-R history and empty counters.
            if (enter_learn) begin
               scnt     <= '0;
               to_cnt   <= '0;
               rr_cnt   <= '0;
               rr_armed <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_qrs_phase_controller.sv
// Bench for qrs_phase_controller: table of learn/detect vectors plus hand sequences for timing corners.
// Latency: expected peaks are queued as stimulus is driven and popped when peak_pulse appears.
// Backpressure: n/a; the bench drives one sample per call and never stalls.
module tb_qrs_phase_controller;

   localparam int DW  = 32;
   localparam int RRW = 16;
   localparam int LL  = 8;
   localparam int RL  = 50;
   localparam int TL  = 64;
   localparam int TS  = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic                 stop;
   logic                 sample_valid;
   logic signed [DW-1:0] sample;
   logic                 lift_en;
   logic                 max_clr;
   logic [DW-1:0]        threshold;
   logic                 thr_valid;
   logic                 peak_pulse;
   logic [DW-1:0]        peak_value;
   logic [RRW-1:0]       rr_interval;
   logic                 rr_valid;
   logic [1:0]           state_o;

   qrs_phase_controller #(
      .DW          (DW),
      .LEARN_LEN   (LL),
      .REFRACT_LEN (RL),
      .TIMEOUT_LEN (TL),
      .THR_SHIFT   (TS),
      .RRW         (RRW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .stop         (stop),
      .sample_valid (sample_valid),
      .sample       (sample),
      .lift_en      (lift_en),
      .max_clr      (max_clr),
      .threshold    (threshold),
      .thr_valid    (thr_valid),
      .peak_pulse   (peak_pulse),
      .peak_value   (peak_value),
      .rr_interval  (rr_interval),
      .rr_valid     (rr_valid),
      .state_o      (state_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pv;
      logic        rv;
      logic [15:0] ri;
   } exp_t;

   typedef struct {
      logic signed [31:0] smp;
      logic [1:0]         st;
      logic               tv;
      logic [31:0]        thr;
      logic [31:0]        pk;   // expected peak_value, 0 = no peak expected
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[12];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d required %0d", nm, act, req);
      end
   endtask

   task automatic send(input logic signed [31:0] v);
      sample       = v;
      sample_valid = 1'b1;
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
   endtask

   task automatic send_n(input int n, input logic signed [31:0] v);
      repeat (n) send(v);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
   endtask

   task automatic expect_peak(input logic [31:0] pv, input logic rv, input logic [15:0] ri);
      exp_t e;
      e.pv = pv;
      e.rv = rv;
      e.ri = ri;
      exp_q.push_back(e);
   endtask

   // Scoreboard: every peak_pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (peak_pulse) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_peak: got peak_value %0d, required no peak", peak_value);
         end else begin
            e = exp_q.pop_front();
            check("peak_value", peak_value, e.pv);
            check("rr_valid", rr_valid, e.rv);
            if (e.rv)
               check("rr_interval", rr_interval, e.ri);
         end
      end else if (rr_valid) begin
         n_cmp++;
         n_bad++;
         $display("FAIL rr_without_peak: got rr_valid 1, required 0");
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{32'sd10,  2'd1, 1'b0, 32'd0,  32'd0};
      vecs[1]  = '{-32'sd40, 2'd1, 1'b0, 32'd0,  32'd0};
      vecs[2]  = '{32'sd25,  2'd1, 1'b0, 32'd0,  32'd0};
      vecs[3]  = '{32'sd5,   2'd1, 1'b0, 32'd0,  32'd0};
      vecs[4]  = '{-32'sd3,  2'd1, 1'b0, 32'd0,  32'd0};
      vecs[5]  = '{32'sd39,  2'd1, 1'b0, 32'd0,  32'd0};
      vecs[6]  = '{32'sd0,   2'd1, 1'b0, 32'd0,  32'd0};
      vecs[7]  = '{32'sd12,  2'd2, 1'b1, 32'd30, 32'd0};
      vecs[8]  = '{32'sd30,  2'd2, 1'b1, 32'd30, 32'd0};
      vecs[9]  = '{-32'sd30, 2'd2, 1'b1, 32'd30, 32'd0};
      vecs[10] = '{32'sd29,  2'd2, 1'b1, 32'd30, 32'd0};
      vecs[11] = '{-32'sd31, 2'd3, 1'b1, 32'd30, 32'd31};

      rst = 1'b1; start = 1'b0; stop = 1'b0; sample_valid = 1'b0; sample = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", state_o, 2'd0);
      check("rst_lift_en", lift_en, 1'b0);
      check("rst_max_clr", max_clr, 1'b0);
      check("rst_threshold", threshold, 32'd0);
      check("rst_thr_valid", thr_valid, 1'b0);
      check("rst_peak_value", peak_value, 32'd0);
      check("rst_rr_interval", rr_interval, 16'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Learn then first detection, table driven.
      pulse_start();
      check("learn_state", state_o, 2'd1);
      check("learn_lift_en", lift_en, 1'b1);
      check("learn_max_clr", max_clr, 1'b1);
      @(posedge clk);
      #1;
      check("max_clr_one_cycle", max_clr, 1'b0);
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].pk != 32'd0)
            expect_peak(vecs[i].pk, 1'b0, 16'd0);
         send(vecs[i].smp);
         check($sformatf("vec%0d_state", i), state_o, vecs[i].st);
         check($sformatf("vec%0d_thr_valid", i), thr_valid, vecs[i].tv);
         check($sformatf("vec%0d_threshold", i), threshold, vecs[i].thr);
      end

      // Refractory length, then a second peak 100 samples after the first.
      send_n(RL - 1, 32'sd1000);
      check("refract_hold", state_o, 2'd3);
      send(32'sd1000);
      check("refract_exit", state_o, 2'd2);
      send_n(49, 32'sd5);
      pulse_start();
      check("start_ignored", state_o, 2'd2);
      expect_peak(32'd200, 1'b1, 16'd100);
      send(32'sd200);
      check("second_peak_state", state_o, 2'd3);
      @(posedge clk);
      #1;
      check("thr_fixed_after_peak", threshold, 32'd30);

      // Timeout back to LEARN, relearn, RR disarmed.
      send_n(RL, 32'sd5);
      send_n(TL - 1, 32'sd5);
      check("timeout_minus1", state_o, 2'd2);
      send(32'sd5);
      check("timeout_state", state_o, 2'd1);
      check("timeout_max_clr", max_clr, 1'b1);
      check("timeout_thr_valid", thr_valid, 1'b1);
      send(32'sd100);
      send_n(LL - 1, 32'sd0);
      check("relearn_state", state_o, 2'd2);
      check("relearn_threshold", threshold, 32'd75);
      expect_peak(32'd80, 1'b0, 16'd0);
      send(32'sd80);
      check("rearm_peak_state", state_o, 2'd3);

      // Peak on the same sample that would time out: the peak wins.
      send_n(RL, 32'sd5);
      send_n(TL - 1, 32'sd75);
      expect_peak(32'd90, 1'b1, 16'd114);
      send(32'sd90);
      check("peak_beats_timeout", state_o, 2'd3);

      // stop and start together: stop wins, threshold kept.
      stop = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      stop = 1'b0;
      start = 1'b0;
      check("stop_state", state_o, 2'd0);
      check("stop_thr_valid", thr_valid, 1'b0);
      check("stop_lift_en", lift_en, 1'b0);
      check("stop_keeps_threshold", threshold, 32'd75);

      // Most negative sample saturates to 2^31-1.
      pulse_start();
      send(32'sh8000_0000);
      send_n(LL - 1, 32'sd3);
      check("sat_threshold", threshold, 32'd1610612736);
      expect_peak(32'h7FFF_FFFF, 1'b0, 16'd0);
      send(32'sh8000_0000);
      check("sat_peak_state", state_o, 2'd3);

      // All-zero learn window publishes threshold 1.
      pulse_stop();
      pulse_start();
      send_n(LL, 32'sd0);
      check("zero_threshold", threshold, 32'd1);
      send(32'sd1);
      check("equal_not_peak", state_o, 2'd2);
      expect_peak(32'd2, 1'b0, 16'd0);
      send(-32'sd2);
      check("above_one_peak", state_o, 2'd3);

      // Asynchronous reset in DETECT with a would-be peak on the input.
      send_n(RL, 32'sd0);
      check("pre_reset_detect", state_o, 2'd2);
      sample       = 32'sd500;
      sample_valid = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check("arst_state", state_o, 2'd0);
      check("arst_threshold", threshold, 32'd0);
      check("arst_thr_valid", thr_valid, 1'b0);
      check("arst_peak_pulse", peak_pulse, 1'b0);
      check("arst_lift_en", lift_en, 1'b0);
      check("arst_peak_value", peak_value, 32'd0);
      check("arst_rr_interval", rr_interval, 16'd0);
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("post_reset_state", state_o, 2'd0);
      check("post_reset_pulse", peak_pulse, 1'b0);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
